// File: rtl/fb_pkg.sv
// Shared types and default widths for the framebuffer arbiter.
package fb_pkg;

  typedef enum logic [0:0] {
    StIdle  = 1'b0,
    StClear = 1'b1
  } fb_state_e;

  localparam int unsigned FB_ADDR_W      = 10;
  localparam int unsigned FB_DATA_W      = 4;
  localparam int unsigned FB_CLEAR_VALUE = 0;

endpackage

// File: rtl/fb_arbiter_if.sv
// Host write bus, scan-out read port and RAM port of the framebuffer arbiter.
interface fb_arbiter_if
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W = FB_ADDR_W,
  parameter int unsigned DATA_W = FB_DATA_W
);
  logic              host_strobe;
  logic [ADDR_W-1:0] host_addr;
  logic [DATA_W-1:0] host_data;
  logic              vid_req;
  logic [ADDR_W-1:0] vid_addr;
  logic              vid_valid;
  logic [DATA_W-1:0] vid_data;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;
  logic [DATA_W-1:0] ram_dout;

  modport slave (
    input  host_strobe, host_addr, host_data, vid_req, vid_addr, ram_dout,
    output vid_valid, vid_data, ram_addr, ram_din, ram_we
  );

  modport master (
    output host_strobe, host_addr, host_data, vid_req, vid_addr, ram_dout,
    input  vid_valid, vid_data, ram_addr, ram_din, ram_we
  );
endinterface

// File: rtl/fb_wr_fifo.sv
// Synchronous FIFO for queued host writes; a push into a full queue is accepted
// only when a pop happens in the same cycle.
module fb_wr_fifo #(
  parameter int unsigned DEPTH = 4,
  parameter int unsigned WIDTH = 14
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic                   push,
  input  logic                   pop,
  input  logic [WIDTH-1:0]       wdata,
  output logic [WIDTH-1:0]       rdata,
  output logic                   full,
  output logic                   empty,
  output logic [$clog2(DEPTH):0] level
);
  localparam int unsigned PTR_W = $clog2(DEPTH);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q, rd_ptr_q;
  logic [PTR_W:0]   level_q;
  logic             do_push, do_pop;

  assign full    = (level_q == (PTR_W+1)'(DEPTH));
  assign empty   = (level_q == '0);
  assign do_pop  = pop & ~empty;
  assign do_push = push & (~full | do_pop);
  assign rdata   = mem_q[rd_ptr_q];
  assign level   = level_q;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      level_q  <= '0;
    end else begin
      if (do_push) wr_ptr_q <= wr_ptr_q + 1'b1;
      if (do_pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
      unique case ({do_push, do_pop})
        2'b10:   level_q <= level_q + 1'b1;
        2'b01:   level_q <= level_q - 1'b1;
        default: level_q <= level_q;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (do_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule

// File: rtl/fb_arbiter.sv
// Framebuffer RAM arbiter: scan-out reads first, then the clear sequencer, then
// queued host writes, one RAM operation per cycle.
module fb_arbiter
  import fb_pkg::*;
#(
  parameter int unsigned ADDR_W      = FB_ADDR_W,
  parameter int unsigned DATA_W      = FB_DATA_W,
  parameter int unsigned FIFO_DEPTH  = 4,
  parameter int unsigned SYNC_STAGES = 2,
  parameter int unsigned CLEAR_VALUE = FB_CLEAR_VALUE
) (
  input  logic                        clk,
  input  logic                        rst_n,
  fb_arbiter_if.slave                 bus,
  input  logic                        clear_start,
  output logic                        clear_busy,
  output logic [$clog2(FIFO_DEPTH):0] fifo_level,
  output logic                        overflow,
  input  logic                        clr_overflow
);
  localparam int unsigned       ENT_W      = ADDR_W + DATA_W;
  localparam logic [DATA_W-1:0] CLEAR_WORD = DATA_W'(CLEAR_VALUE);
  localparam logic [ADDR_W-1:0] LAST_ADDR  = '1;

  logic [SYNC_STAGES-1:0] sync_q;
  logic                   strobe_prev_q;
  logic                   host_rise;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q        <= '0;
      strobe_prev_q <= 1'b0;
    end else begin
      sync_q        <= {sync_q[SYNC_STAGES-2:0], bus.host_strobe};
      strobe_prev_q <= sync_q[SYNC_STAGES-1];
    end
  end

  assign host_rise = sync_q[SYNC_STAGES-1] & ~strobe_prev_q;

  logic [ENT_W-1:0]  fifo_head;
  logic [ADDR_W-1:0] head_addr;
  logic [DATA_W-1:0] head_data;
  logic              fifo_full, fifo_empty, fifo_pop;

  fb_wr_fifo #(
    .DEPTH (FIFO_DEPTH),
    .WIDTH (ENT_W)
  ) u_wr_fifo (
    .clk   (clk),
    .rst_n (rst_n),
    .push  (host_rise),
    .pop   (fifo_pop),
    .wdata ({bus.host_addr, bus.host_data}),
    .rdata (fifo_head),
    .full  (fifo_full),
    .empty (fifo_empty),
    .level (fifo_level)
  );

  assign {head_addr, head_data} = fifo_head;

  fb_state_e         state_q;
  logic [ADDR_W-1:0] clr_ptr_q, addr_q;
  logic [DATA_W-1:0] din_q;
  logic              vid_valid_q, overflow_q, clr_step;
  logic [ADDR_W-1:0] ram_addr;
  logic [DATA_W-1:0] ram_din;
  logic              ram_we;

  // No RAM operation is issued while reset is held, so the port rests at its reset values.
  always_comb begin
    ram_we   = 1'b0;
    ram_addr = addr_q;
    ram_din  = din_q;
    fifo_pop = 1'b0;
    clr_step = 1'b0;
    if (!rst_n) begin
      ram_we = 1'b0;
    end else if (bus.vid_req) begin
      ram_addr = bus.vid_addr;
    end else if (state_q == StClear) begin
      ram_we   = 1'b1;
      ram_addr = clr_ptr_q;
      ram_din  = CLEAR_WORD;
      clr_step = 1'b1;
    end else if (!fifo_empty) begin
      ram_we   = 1'b1;
      ram_addr = head_addr;
      ram_din  = head_data;
      fifo_pop = 1'b1;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= StClear;
      clr_ptr_q   <= '0;
      addr_q      <= '0;
      din_q       <= '0;
      vid_valid_q <= 1'b0;
      overflow_q  <= 1'b0;
    end else begin
      vid_valid_q <= bus.vid_req;
      addr_q      <= ram_addr;
      din_q       <= ram_din;
      unique case (state_q)
        StIdle: begin
          if (clear_start) begin
            state_q   <= StClear;
            clr_ptr_q <= '0;
          end
        end
        StClear: begin
          if (clr_step) begin
            clr_ptr_q <= clr_ptr_q + 1'b1;
            if (clr_ptr_q == LAST_ADDR) state_q <= StIdle;
          end
        end
        default: state_q <= StIdle;
      endcase
      // A dropped push wins over a same-cycle clear request.
      if (host_rise && fifo_full && !fifo_pop) begin
        overflow_q <= 1'b1;
      end else if (clr_overflow) begin
        overflow_q <= 1'b0;
      end
    end
  end

  assign bus.ram_we    = ram_we;
  assign bus.ram_addr  = ram_addr;
  assign bus.ram_din   = ram_din;
  assign bus.vid_valid = vid_valid_q;
  assign bus.vid_data  = vid_valid_q ? bus.ram_dout : '0;
  assign clear_busy    = (state_q == StClear);
  assign overflow      = overflow_q;

endmodule

// File: tb/tb_fb_arbiter.sv
// Directed bench for fb_arbiter with a behavioural single-port sync-read RAM.
module tb_fb_arbiter;
  localparam int unsigned ADDR_W      = 10;
  localparam int unsigned DATA_W      = 4;
  localparam int unsigned FIFO_DEPTH  = 4;
  localparam int unsigned SYNC_STAGES = 2;

  logic       clk = 1'b0;
  logic       rst_n = 1'b0;
  logic       clear_start = 1'b0;
  logic       clr_overflow = 1'b0;
  logic       clear_busy, overflow;
  logic [2:0] fifo_level;

  fb_arbiter_if #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) bus ();

  fb_arbiter #(
    .ADDR_W      (ADDR_W),
    .DATA_W      (DATA_W),
    .FIFO_DEPTH  (FIFO_DEPTH),
    .SYNC_STAGES (SYNC_STAGES),
    .CLEAR_VALUE (0)
  ) dut (
    .clk          (clk),
    .rst_n        (rst_n),
    .bus          (bus),
    .clear_start  (clear_start),
    .clear_busy   (clear_busy),
    .fifo_level   (fifo_level),
    .overflow     (overflow),
    .clr_overflow (clr_overflow)
  );

  always #5 clk = ~clk;

  // RAM model, pre-filled with 0xF so the clear is observable.
  logic [3:0] mem [1024];
  logic       mem_ready = 1'b0;
  always @(posedge clk) begin
    if (!mem_ready) begin
      for (int i = 0; i < 1024; i++) mem[i] <= 4'hF;
      mem_ready <= 1'b1;
    end else if (bus.ram_we) begin
      mem[bus.ram_addr] <= bus.ram_din;
    end
    bus.ram_dout <= mem[bus.ram_addr];
  end

  int checks = 0;
  int passes = 0;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) passes++;
    else $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
  endtask

  task automatic cyc(input int n);
    repeat (n) @(posedge clk);
    #2;
  endtask

  int n, bad, a5, lvl20;

  initial begin
    bus.host_strobe = 1'b0;
    bus.host_addr   = '0;
    bus.host_data   = '0;
    bus.vid_req     = 1'b0;
    bus.vid_addr    = '0;

    // Reset state
    cyc(2);
    check("rst_vid_valid", 32'(bus.vid_valid), 0);
    check("rst_vid_data", 32'(bus.vid_data), 0);
    check("rst_ram_we", 32'(bus.ram_we), 0);
    check("rst_ram_addr", 32'(bus.ram_addr), 0);
    check("rst_ram_din", 32'(bus.ram_din), 0);
    check("rst_fifo_level", 32'(fifo_level), 0);
    check("rst_overflow", 32'(overflow), 0);
    check("rst_clear_busy", 32'(clear_busy), 1);

    // Power-up clear: 1024 writes of 0 to addresses 0..1023
    rst_n = 1'b1;
    #1;
    n = 0;
    bad = 0;
    while (clear_busy && n < 2000) begin
      if (!(bus.ram_we === 1'b1 && bus.ram_addr === n[9:0] && bus.ram_din === 4'h0)) bad++;
      n++;
      cyc(1);
    end
    check("clr_length", 32'(n), 1024);
    check("clr_bad_writes", 32'(bad), 0);
    check("clr_idle_we", 32'(bus.ram_we), 0);
    check("clr_mem_first", 32'(mem[0]), 0);
    check("clr_mem_last", 32'(mem[1023]), 0);

    // Single host write: issued at the (SYNC_STAGES+2)th edge after the strobe
    bus.host_addr   = 10'h155;
    bus.host_data   = 4'h5;
    bus.host_strobe = 1'b1;
    cyc(2);
    check("wr_lvl_early", 32'(fifo_level), 0);
    check("wr_we_early", 32'(bus.ram_we), 0);
    cyc(1);
    check("wr_we", 32'(bus.ram_we), 1);
    check("wr_addr", 32'(bus.ram_addr), 32'h155);
    check("wr_din", 32'(bus.ram_din), 32'h5);
    check("wr_lvl", 32'(fifo_level), 1);
    cyc(1);
    check("wr_we_after", 32'(bus.ram_we), 0);
    check("wr_lvl_after", 32'(fifo_level), 0);
    check("wr_mem", 32'(mem[10'h155]), 32'h5);
    bus.host_strobe = 1'b0;
    cyc(3);

    // Scan-out read of the written word
    bus.vid_req  = 1'b1;
    bus.vid_addr = 10'h155;
    #1;
    check("rd_we", 32'(bus.ram_we), 0);
    check("rd_addr", 32'(bus.ram_addr), 32'h155);
    cyc(1);
    bus.vid_req = 1'b0;
    #1;
    check("rd_valid", 32'(bus.vid_valid), 1);
    check("rd_data", 32'(bus.vid_data), 32'h5);
    cyc(1);
    check("rd_valid_off", 32'(bus.vid_valid), 0);
    check("rd_data_off", 32'(bus.vid_data), 0);

    // Overflow under sustained video reads, then in-order drain
    bus.vid_req  = 1'b1;
    bus.vid_addr = 10'h000;
    for (int k = 0; k < 5; k++) begin
      bus.host_addr   = 10'h200 + 10'(k);
      bus.host_data   = 4'(k + 1);
      bus.host_strobe = 1'b1;
      cyc(4);
      bus.host_strobe = 1'b0;
      cyc(3);
    end
    check("ovf_level", 32'(fifo_level), 4);
    check("ovf_flag", 32'(overflow), 1);
    bus.vid_req = 1'b0;
    #1;
    for (int k = 0; k < 4; k++) begin
      check($sformatf("drain%0d_we", k), 32'(bus.ram_we), 1);
      check($sformatf("drain%0d_addr", k), 32'(bus.ram_addr), 32'h200 + 32'(k));
      check($sformatf("drain%0d_din", k), 32'(bus.ram_din), 32'(k + 1));
      cyc(1);
    end
    check("drain_we_off", 32'(bus.ram_we), 0);
    check("drain_level", 32'(fifo_level), 0);
    check("ovf_sticky", 32'(overflow), 1);
    clr_overflow = 1'b1;
    cyc(1);
    clr_overflow = 1'b0;
    check("ovf_cleared", 32'(overflow), 0);

    // Host write queued mid-clear survives; clear_start during clear is ignored
    clear_start = 1'b1;
    cyc(1);
    clear_start = 1'b0;
    n = 0;
    a5 = 0;
    lvl20 = 0;
    while (clear_busy && n < 2000) begin
      if (n == 5) begin
        a5 = 32'(bus.ram_addr);
        bus.host_addr   = 10'h010;
        bus.host_data   = 4'hA;
        bus.host_strobe = 1'b1;
      end
      if (n == 12) bus.host_strobe = 1'b0;
      if (n == 20) lvl20 = 32'(fifo_level);
      clear_start = (n == 100);
      n++;
      cyc(1);
    end
    clear_start = 1'b0;
    check("mid_ptr5", 32'(a5), 5);
    check("mid_queued", 32'(lvl20), 1);
    check("mid_clr_length", 32'(n), 1024);
    check("mid_drain_we", 32'(bus.ram_we), 1);
    check("mid_drain_addr", 32'(bus.ram_addr), 32'h010);
    check("mid_drain_din", 32'(bus.ram_din), 32'hA);
    cyc(1);
    check("mid_mem", 32'(mem[10'h010]), 32'hA);
    bus.vid_req  = 1'b1;
    bus.vid_addr = 10'h010;
    cyc(1);
    bus.vid_req = 1'b0;
    #1;
    check("mid_rd_data", 32'(bus.vid_data), 32'hA);
    cyc(1);

    // Reset mid-clear with two queued writes and a read in flight
    clear_start = 1'b1;
    cyc(1);
    clear_start = 1'b0;
    cyc(20);
    for (int k = 0; k < 2; k++) begin
      bus.host_addr   = 10'h300 + 10'(k);
      bus.host_data   = 4'(k + 7);
      bus.host_strobe = 1'b1;
      cyc(4);
      bus.host_strobe = 1'b0;
      cyc(3);
    end
    check("rr_level", 32'(fifo_level), 2);
    check("rr_busy", 32'(clear_busy), 1);
    bus.vid_req  = 1'b1;
    bus.vid_addr = 10'h010;
    cyc(1);
    check("rr_vid_valid", 32'(bus.vid_valid), 1);
    rst_n = 1'b0;
    #1;
    check("rr_rst_level", 32'(fifo_level), 0);
    check("rr_rst_overflow", 32'(overflow), 0);
    check("rr_rst_vid_valid", 32'(bus.vid_valid), 0);
    check("rr_rst_vid_data", 32'(bus.vid_data), 0);
    check("rr_rst_we", 32'(bus.ram_we), 0);
    bus.vid_req = 1'b0;
    cyc(1);
    rst_n = 1'b1;
    #1;
    check("rr_restart_we", 32'(bus.ram_we), 1);
    check("rr_restart_addr0", 32'(bus.ram_addr), 0);
    check("rr_restart_busy", 32'(clear_busy), 1);
    cyc(1);
    check("rr_restart_addr1", 32'(bus.ram_addr), 1);
    check("rr_restart_level", 32'(fifo_level), 0);

    $display("%0d/%0d checks passed", passes, checks);
    $finish;
  end

endmodule
